// File: rtl/xgmii_rx_engine_pkg.sv
// Shared constants for the XGMII receive engine: frame tags, header fields,
// XGMII control codes and the CRC32 helpers.
package xgmii_rx_engine_pkg;

  localparam logic [31:0] MAGIC_CODE     = 32'hC0DE_CAFE;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] UDP_PORT       = 16'h0009;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TOS         = 8'h00;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam logic [7:0]  CODE_START     = 8'hFB;
  localparam logic [7:0]  CODE_TERM      = 8'hFD;
  localparam logic [7:0]  CODE_IDLE      = 8'h07;
  // Start character in lane 0 followed by the 6x 0x55 preamble and the SFD.
  localparam logic [63:0] PREAMBLE       = {8'hD5, {6{8'h55}}, CODE_START};

  localparam logic [7:0]  CTRL_PAYLOAD   = 8'h00;
  localparam logic [7:0]  CTRL_LAST      = 8'h01;

  localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT       = '1;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/xgmii_rx_engine_crc32_d64.sv
// CRC32 over one 64-bit XGMII word: lane 0 first, each byte LSB first,
// non-reflected register (output is bit-reversed and complemented by the user).
module crc32_d64
  import xgmii_rx_engine_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data_in,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 64; i++) begin
      if (c[31] ^ data_in[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                    c = {c[30:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/xgmii_rx_engine.sv
// XGMII receive engine: filters UDP frames for this interface, checks FCS,
// stages the payload and commits it to the FIFO only once the frame is good.
module xgmii_rx_engine
  import xgmii_rx_engine_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] xgmii_rxd,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  input  logic [31:0] if_v4addr,
  input  logic [47:0] if_macaddr,
  output logic [31:0] rx_good_count,
  output logic [31:0] rx_drop_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_DROP    = 3'd4;

  localparam int unsigned IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    w_q, w_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [31:0]   crc_q, crc_d, crc_next;
  logic          shadow_q, shadow_d;
  logic          wr_en_q, wr_en_d;
  logic [71:0]   din_q, din_d;
  logic [31:0]   good_q, good_d, drop_q, drop_d;
  logic [63:0]   stage_q [MAX_WORDS];
  logic          stage_we;

  logic [7:0]  rxc;
  logic [63:0] rxd;
  logic        is_start, is_term4, has_term, fcs_ok, hdr_ok;

  assign rxc = xgmii_rxd[71:64];
  assign rxd = xgmii_rxd[63:0];

  crc32_d64 u_crc (
    .crc_in  (crc_q),
    .data_in (rxd),
    .crc_out (crc_next)
  );

  assign is_start = (rxc == 8'h01) && (rxd == PREAMBLE);
  assign is_term4 = (rxc == 8'hF0) && (rxd[39:32] == CODE_TERM);
  assign fcs_ok   = (rxd[31:0] == ~bitrev32(crc_q));

  always_comb begin
    has_term = 1'b0;
    for (int unsigned i = 0; i < 8; i++)
      if (rxc[i] && (rxd[8*i +: 8] == CODE_TERM)) has_term = 1'b1;
  end

  // Header fields arrive first-byte-in-lane-0, so multi-byte fields are byte swapped.
  always_comb begin
    case (w_q)
      3'd1: hdr_ok = ({rxd[7:0], rxd[15:8], rxd[23:16], rxd[31:24], rxd[39:32], rxd[47:40]}
                      == if_macaddr);
      3'd2: hdr_ok = ({rxd[39:32], rxd[47:40]} == ETHERTYPE_IPV4) &&
                     (rxd[55:48] == IP_VER_IHL) && (rxd[63:56] == IP_TOS);
      3'd3: hdr_ok = (rxd[63:56] == IP_PROTO_UDP);
      3'd4: hdr_ok = ({rxd[55:48], rxd[63:56]} == if_v4addr[31:16]);
      3'd5: hdr_ok = ({rxd[7:0], rxd[15:8]} == if_v4addr[15:0]) &&
                     ({rxd[39:32], rxd[47:40]} == UDP_PORT);
      3'd6: hdr_ok = ({rxd[23:16], rxd[31:24], rxd[39:32], rxd[47:40]} == MAGIC_CODE);
      default: hdr_ok = 1'b0;
    endcase
  end

  always_comb begin
    logic good_inc, drop_inc;
    state_d  = state_q;
    w_d      = w_q;
    pcnt_d   = pcnt_q;
    rd_d     = rd_q;
    crc_d    = crc_q;
    shadow_d = shadow_q;
    wr_en_d  = 1'b0;
    din_d    = din_q;
    stage_we = 1'b0;
    good_inc = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          state_d = S_HDR;
          w_d     = 3'd1;
          pcnt_d  = '0;
          crc_d   = CRC_INIT;
        end
      end
      S_HDR, S_PAYLOAD: begin
        if (rxc != '0) begin
          if (is_term4) begin
            if (!fcs_ok) begin
              state_d  = S_IDLE;
              drop_inc = 1'b1;
            end else if (pcnt_q == '0) begin
              state_d  = S_IDLE;
              good_inc = 1'b1;
            end else begin
              // First write is registered together with the terminate word.
              state_d = S_FLUSH;
              rd_d    = '0;
              if (!full) begin
                wr_en_d = 1'b1;
                din_d   = {(pcnt_q == CW'(1)) ? CTRL_LAST : CTRL_PAYLOAD, stage_q[0]};
                rd_d    = CW'(1);
              end
            end
          end else if (has_term) begin
            state_d  = S_IDLE;
            drop_inc = 1'b1;
          end else begin
            state_d = S_DROP;
          end
        end else begin
          crc_d = crc_next;
          if (state_q == S_HDR) begin
            if (!hdr_ok)           state_d = S_DROP;
            else if (w_q == 3'd6)  state_d = S_PAYLOAD;
            else                   w_d     = w_q + 3'd1;
          end else if (pcnt_q == CW'(MAX_WORDS)) begin
            state_d = S_DROP;
          end else begin
            stage_we = 1'b1;
            pcnt_d   = pcnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        // A frame arriving mid-flush is shadowed so its terminate is not mistaken for a new frame.
        if (is_start) shadow_d = 1'b1;
        if (shadow_q && has_term) begin
          shadow_d = 1'b0;
          drop_inc = 1'b1;
        end
        if (rd_q == pcnt_q) begin
          good_inc = 1'b1;
          state_d  = shadow_d ? S_DROP : S_IDLE;
          shadow_d = 1'b0;
        end else if (!full) begin
          wr_en_d = 1'b1;
          din_d   = {((rd_q + CW'(1)) == pcnt_q) ? CTRL_LAST : CTRL_PAYLOAD,
                     stage_q[rd_q[IW-1:0]]};
          rd_d    = rd_q + CW'(1);
        end
      end
      S_DROP: begin
        if (has_term) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    good_d = good_q + 32'(good_inc);
    drop_d = drop_q + 32'(drop_inc);
  end

  always_ff @(posedge xgmii_clk) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      pcnt_q   <= '0;
      rd_q     <= '0;
      crc_q    <= CRC_INIT;
      shadow_q <= 1'b0;
      wr_en_q  <= 1'b0;
      din_q    <= '0;
      good_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      pcnt_q   <= pcnt_d;
      rd_q     <= rd_d;
      crc_q    <= crc_d;
      shadow_q <= shadow_d;
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
      good_q   <= good_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge xgmii_clk) begin
    if (stage_we) stage_q[pcnt_q[IW-1:0]] <= rxd;
  end

  assign din           = din_q;
  assign wr_en         = wr_en_q;
  assign rx_good_count = good_q;
  assign rx_drop_count = drop_q;

endmodule

// File: tb/tb_xgmii_rx_engine.sv
// Directed bench for xgmii_rx_engine: builds Ethernet/IPv4/UDP frames with a
// reflected, byte-wise FCS model and checks FIFO writes and counters.
module tb_xgmii_rx_engine;
  import xgmii_rx_engine_pkg::MAGIC_CODE;

  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'hC0A8_0164;
  localparam logic [63:0] IDLE_W  = {8{8'h07}};
  localparam logic [63:0] PRE_W   = 64'hD555_5555_5555_55FB;

  logic        clk = 1'b0;
  logic        rst_n, full, wr_en;
  logic [71:0] rx, din;
  logic [31:0] good, drop;

  int unsigned n_run = 0, n_fail = 0;
  logic [71:0] cap[$];
  logic [7:0]  fb[$];
  logic        prev_full = 1'b0;
  logic [71:0] din_prev = '0;

  xgmii_rx_engine #(.MAX_WORDS(16)) dut (
    .xgmii_clk     (clk),
    .sys_rst_n     (rst_n),
    .xgmii_rxd     (rx),
    .din           (din),
    .wr_en         (wr_en),
    .full          (full),
    .if_v4addr     (MY_IP),
    .if_macaddr    (MY_MAC),
    .rx_good_count (good),
    .rx_drop_count (drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) prev_full = full;

  always @(negedge clk) begin
    if (prev_full) begin
      check_eq("stall_wr_en", {71'b0, wr_en}, 72'd0);
      check_eq("stall_din_hold", din, din_prev);
    end
    if (wr_en) cap.push_back(din);
    din_prev = din;
  end

  task automatic put(input logic [7:0] c, input logic [63:0] d);
    @(negedge clk);
    rx = {c, d};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(8'hFF, IDLE_W);
  endtask

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] mac, input int npay);
    fb.delete();
    push_bytes({16'h0, mac}, 6);
    push_bytes(64'h02_00_00_00_00_01, 6);
    push_bytes(64'h0800_4500, 4);
    push_bytes(64'h0000_0000_4000_4011, 8);
    push_bytes(64'h0000_C0A8_0102, 6);
    push_bytes({32'h0, MY_IP}, 4);
    push_bytes(64'h1234_0009_0000_0000, 8);
    push_bytes({32'h0, MAGIC_CODE}, 4);
    push_bytes(64'h0, 2);
    for (int k = 0; k < 8 * npay; k++) fb.push_back(8'(k));
  endtask

  function automatic logic [31:0] fcs_of();
    logic [31:0] c = '1;
    foreach (fb[i]) begin
      c ^= {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send_frame(input logic [47:0] mac, input int npay,
                            input logic [7:0] fcs_xor, input bit term_l2);
    logic [31:0] f;
    logic [63:0] w;
    build(mac, npay);
    f = fcs_of();
    put(8'h01, PRE_W);
    for (int i = 0; i < fb.size() / 8; i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = fb[8*i + j];
      put(8'h00, w);
    end
    if (term_l2) put(8'hFC, {40'h07_0707_0707, 8'hFD, f[15:0]});
    else         put(8'hF0, {24'h07_0707, 8'hFD, f[31:8], f[7:0] ^ fcs_xor});
  endtask

  function automatic logic [71:0] cap_at(input int i);
    return (i < cap.size()) ? cap[i] : 72'h0;
  endfunction

  initial begin
    rx    = {8'hFF, IDLE_W};
    full  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_wr_en", {71'b0, wr_en}, 72'd0);
    check_eq("rst_din", din, 72'h0);
    check_eq("rst_good", {40'b0, good}, 72'd0);
    check_eq("rst_drop", {40'b0, drop}, 72'd0);
    idle(2);

    // 68-byte good frame with two payload words
    cap.delete();
    send_frame(MY_MAC, 2, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("first_wr_latency", {71'b0, wr_en}, 72'd1);
    idle(10);
    check_eq("good_nwords", 72'(cap.size()), 72'd2);
    check_eq("good_w0", cap_at(0), {8'h00, 64'h0706_0504_0302_0100});
    check_eq("good_w1", cap_at(1), {8'h01, 64'h0F0E_0D0C_0B0A_0908});
    check_eq("good_cnt1", {40'b0, good}, 72'd1);
    check_eq("drop_cnt0", {40'b0, drop}, 72'd0);

    // bad FCS
    cap.delete();
    send_frame(MY_MAC, 2, 8'h01, 1'b0);
    idle(10);
    check_eq("badfcs_nwords", 72'(cap.size()), 72'd0);
    check_eq("badfcs_drop", {40'b0, drop}, 72'd1);

    // wrong destination MAC, then a good frame
    send_frame(MY_MAC ^ 48'h00_00_00_00_10_00, 2, 8'h00, 1'b0);
    idle(5);
    check_eq("badmac_nwords", 72'(cap.size()), 72'd0);
    check_eq("badmac_drop", {40'b0, drop}, 72'd2);
    send_frame(MY_MAC, 2, 8'h00, 1'b0);
    idle(10);
    check_eq("after_badmac_w0", cap_at(0), {8'h00, 64'h0706_0504_0302_0100});
    check_eq("after_badmac_w1", cap_at(1), {8'h01, 64'h0F0E_0D0C_0B0A_0908});
    check_eq("after_badmac_good", {40'b0, good}, 72'd2);

    // FIFO full for three cycles right after the first write
    cap.delete();
    send_frame(MY_MAC, 4, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("stall_first_wr", {71'b0, wr_en}, 72'd1);
    full = 1'b1;
    repeat (3) @(negedge clk);
    full = 1'b0;
    idle(10);
    check_eq("stall_nwords", 72'(cap.size()), 72'd4);
    check_eq("stall_w0", cap_at(0), {8'h00, 64'h0706_0504_0302_0100});
    check_eq("stall_w1", cap_at(1), {8'h00, 64'h0F0E_0D0C_0B0A_0908});
    check_eq("stall_w2", cap_at(2), {8'h00, 64'h1716_1514_1312_1110});
    check_eq("stall_w3", cap_at(3), {8'h01, 64'h1F1E_1D1C_1B1A_1918});
    check_eq("stall_good", {40'b0, good}, 72'd3);

    // terminate in lane 2, then a payload overrun
    cap.delete();
    send_frame(MY_MAC, 1, 8'h00, 1'b1);
    idle(3);
    send_frame(MY_MAC, 20, 8'h00, 1'b0);
    idle(10);
    check_eq("l2_ovf_nwords", 72'(cap.size()), 72'd0);
    check_eq("l2_ovf_drop", {40'b0, drop}, 72'd4);
    check_eq("l2_ovf_good", {40'b0, good}, 72'd3);

    // reset pulse during flush
    cap.delete();
    send_frame(MY_MAC, 8, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rstflush_wr_en", {71'b0, wr_en}, 72'd0);
    check_eq("rstflush_din", din, 72'h0);
    check_eq("rstflush_good", {40'b0, good}, 72'd0);
    check_eq("rstflush_drop", {40'b0, drop}, 72'd0);
    idle(15);
    check_eq("rstflush_nwords", 72'(cap.size()), 72'd2);
    cap.delete();
    send_frame(MY_MAC, 2, 8'h00, 1'b0);
    idle(10);
    check_eq("post_rst_w0", cap_at(0), {8'h00, 64'h0706_0504_0302_0100});
    check_eq("post_rst_w1", cap_at(1), {8'h01, 64'h0F0E_0D0C_0B0A_0908});
    check_eq("post_rst_good", {40'b0, good}, 72'd1);
    check_eq("post_rst_drop", {40'b0, drop}, 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_rx_engine.md
# xgmii_rx_engine

Receive-side counterpart of the XGMII transmit engine. It monitors the 72-bit XGMII receive bus and parses lane-0-aligned Ethernet/IPv4/UDP frames addressed to this interface that carry the `MAGIC_CODE` tag. It verifies the FCS, stages the payload words, and commits them to a write-side FIFO (72-bit words) only after the frame is proven good. It sits between the 10G PHY/PCS receive path and the PCIe-side FIFO, in the `xgmii_clk` domain.

## Interface
- MAX_WORDS, 16: payload staging depth in 64-bit words; 2..64.
- xgmii_clk  in  1  receive clock; all logic on its rising edge.
- sys_rst_n  in  1  reset; synchronous, active-low.
- xgmii_rxd  in  72  {rxc[7:0], rxd[63:0]}; lane n = rxd[8n+7:8n], control bit rxc[n].
- din  out  72  FIFO write data {ctrl[7:0], data[63:0]}; ctrl 8'h00 = payload word, 8'h01 = last word of frame.
- wr_en  out  1  FIFO write strobe; one word per asserted cycle.
- full  in  1  FIFO full; wr_en must not be asserted while full=1.
- if_v4addr  in  32  local IPv4 address (host order, [31:24] first on wire).
- if_macaddr  in  48  local MAC ([47:40] first on wire).
- rx_good_count  out  32  frames committed, wraps at 2^32.
- rx_drop_count  out  32  frames discarded, wraps at 2^32.

## Operation
- States: IDLE, HDR, PAYLOAD, FLUSH, DROP.
- IDLE: a word with rxc=8'h01, lane0=8'hFB, lanes1–6=8'h55, lane7=8'hD5 -> HDR, word index w=1, CRC reset. Start in any other lane or a malformed preamble -> ignored.
- HDR (w=1..6), checks per 64-bit word, in wire order:
  - w1: dest MAC = if_macaddr.
  - w2: ethertype 0x0800, bytes 0x45, 0x00.
  - w3: protocol 0x11.
  - w4: dst IP high 16 bits = if_v4addr[31:16].
  - w5: dst IP low 16 bits; UDP dst port 0x0009.
  - w6: bytes 2–5 = MAGIC_CODE[31:24..7:0]; bytes 0–1 and 6–7 are ignored.
  - Any mismatch -> DROP.
- PAYLOAD: w≥7 words are stored in the staging buffer at index w−7.
- Every non-terminate frame word from w=1 feeds the CRC32 (64-bit) engine.
- Any rxc bit set in HDR/PAYLOAD:
  - Terminate lane 4 (rxc=8'hF0, lane4=8'hFD) -> FCS check. Lanes 0–3 must equal the bit-reversed, complemented CRC in the transmitter's lane order.
  - Pass with ≥1 payload word -> FLUSH. Pass with 0 payload words -> IDLE, good++. Fail -> IDLE, drop++.
  - Terminate in any other lane, or any other control character -> drop++. Go to IDLE if the word terminates, else DROP.
- Payload beyond MAX_WORDS -> DROP.
- DROP: wait for any word containing 8'hFD with its rxc bit set -> IDLE, drop++.
- FLUSH: write staged words in order. The last word has ctrl 8'h01, all others 8'h00. Stall while full=1. After the last write: good++ -> IDLE.
  - A start detected during FLUSH -> that frame is dropped (drop++), and its terminate is tracked so the engine does not resynchronise mid-frame.
- Counters: increment by exactly 1 per frame. When two events fall in one cycle, good and drop increment independently.

## Timing
- Reset (sys_rst_n=0 at a clock edge): state IDLE, wr_en=0, din=72'h0, both counters 0.
  - Reset mid-frame or mid-flush abandons the frame: no further writes, no count.
- The FCS decision is made in the cycle the terminate word is sampled; the CRC register holds the result for all words before it.
- First wr_en is asserted on the cycle after the terminate word is sampled (registered output).
- Then one word per cycle while full=0. wr_en=0 on every cycle where full=1 was sampled at the preceding edge; din is held.
- IDLE is re-entered the cycle after the last write. Back-to-back frames separated by ≥1 idle word are received once FLUSH completes.

## Structure
- Shared constants go in the common setup header alongside `MAGIC_CODE`: ethertype 0x0800, UDP port 0x0009, start/terminate/idle codes (FB/FD/07), preamble pattern.
- The state encoding parameters are local to the module.
- Sub-module: reuse `crc32_d64` with the same input bit ordering and output bit reversal as the transmit engine. The staging buffer is an inline register array.

## Test plan
- Transmit-engine-format 68-byte frame, matching MAC/IP: payload 0x0706050403020100, 0x0F0E0D0C0B0A0908 -> din {8'h00, …0100} then {8'h01, …0908}, rx_good_count=1.
- Same frame with FCS byte 0 flipped -> no wr_en, rx_drop_count=1.
- Dest MAC differs in one bit -> DROP, no writes, drop=1. The next good frame is committed normally.
- full held high for 3 cycles after the first write -> wr_en low those 3 cycles, din held, all words delivered once in order.
- Terminate in lane 2 -> dropped. A 20-payload-word frame with MAX_WORDS=16 -> dropped. drop=2, no writes.
- sys_rst_n low for 1 cycle during FLUSH -> wr_en=0 the next cycle, counters 0. A subsequent good frame is committed.
